cordic_gain_comp: RTL and testbench

Downstream stage of the CORDIC rotator; consumes its x/y/z results and removes the CORDIC gain by multiplying x and y by 1/P (≈0.607253).
Sequential shift-add multiplier: x and y run in parallel, one coefficient bit per cycle; no DSP multiplier.
z passes through aligned with x/y.
Valid/ready on both sides so a downstream consumer can stall it.

---
 rtl/cordic_gain_comp.sv | 177 +++++++++++++++++
 tb/tb_cordic_gain_comp.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: removes the CORDIC rotator gain from x/y by multiplying
// both by K_INV/2^FRAC_BITS (~0.607253) with a bit-serial shift-add loop,
// one coefficient bit per cycle, x and y in parallel. z rides alongside and
// is presented together with the scaled x/y. Valid/ready on both sides.
//
// Optional build macro: CORDIC_GAIN_COMP_BYPASS_EN
//   Adds a 'bypass' input sampled with the operands; a bypassed sample skips
//   the multiply loop and is presented unscaled one cycle after acceptance.
module cordic_gain_comp #(
   parameter int POINT_WIDTH = 16,
   parameter int ANGLE_WIDTH = 16,
   parameter int FRAC_BITS   = 15,
   parameter int K_INV       = 19898
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef CORDIC_GAIN_COMP_BYPASS_EN
   input  logic                   bypass,
`endif
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [POINT_WIDTH-1:0] x_in,
   input  logic [POINT_WIDTH-1:0] y_in,
   input  logic [ANGLE_WIDTH-1:0] z_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [POINT_WIDTH-1:0] x_out,
   output logic [POINT_WIDTH-1:0] y_out,
   output logic [ANGLE_WIDTH-1:0] z_out
);

   // Accumulator holds operand * coefficient at full precision. Because the
   // coefficient is below 1.0 the product magnitude never exceeds the operand
   // range shifted by FRAC_BITS, so one guard bit is enough.
   localparam int AW = POINT_WIDTH + FRAC_BITS + 1;
   localparam int CW = $clog2(FRAC_BITS + 1);

   localparam logic [FRAC_BITS:0]    KCOEF = (FRAC_BITS + 1)'(K_INV);
   localparam logic [CW-1:0]         LAST  = CW'(FRAC_BITS);
   localparam logic signed [AW-1:0]  HALF  = AW'(1 << (FRAC_BITS - 1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                  state_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic                    bypass_q;
   logic [CW-1:0]           cnt_q;
   logic signed [AW-1:0]    op_x_q;
   logic signed [AW-1:0]    op_y_q;
   logic signed [AW-1:0]    acc_x_q;
   logic signed [AW-1:0]    acc_y_q;
   logic [ANGLE_WIDTH-1:0]  z_q;
   logic [POINT_WIDTH-1:0]  x_out_q;
   logic [POINT_WIDTH-1:0]  y_out_q;
   logic [ANGLE_WIDTH-1:0]  z_out_q;

   logic signed [AW-1:0]    term_x_d;
   logic signed [AW-1:0]    term_y_d;
   logic signed [AW-1:0]    acc_x_d;
   logic signed [AW-1:0]    acc_y_d;
   logic                    byp_w;

`ifdef CORDIC_GAIN_COMP_BYPASS_EN
   assign byp_w = bypass;
`else
   assign byp_w = 1'b0;
`endif

   // Sign-extend a sample to accumulator width.
   function automatic logic signed [AW-1:0] sext(input logic [POINT_WIDTH-1:0] v);
      return AW'($signed(v));
   endfunction

   // Round half up, then drop the fractional bits; the result always fits.
   function automatic logic [POINT_WIDTH-1:0] round_q(input logic signed [AW-1:0] acc);
      logic signed [AW-1:0] biased;
      logic signed [AW-1:0] shifted;
      biased  = acc + HALF;
      shifted = biased >>> FRAC_BITS;
      return shifted[POINT_WIDTH-1:0];
   endfunction

   // Partial product for the current coefficient bit and the running sums.
   always_comb begin
      term_x_d = '0;
      term_y_d = '0;
      if (KCOEF[cnt_q]) begin
         term_x_d = op_x_q <<< cnt_q;
         term_y_d = op_y_q <<< cnt_q;
      end
      acc_x_d = acc_x_q + term_x_d;
      acc_y_d = acc_y_q + term_y_d;
   end

   // Control FSM with operand capture, shift-add loop and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         bypass_q    <= 1'b0;
         cnt_q       <= '0;
         op_x_q      <= '0;
         op_y_q      <= '0;
         acc_x_q     <= '0;
         acc_y_q     <= '0;
         z_q         <= '0;
         x_out_q     <= '0;
         y_out_q     <= '0;
         z_out_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  op_x_q     <= sext(x_in);
                  op_y_q     <= sext(y_in);
                  z_q        <= z_in;
                  bypass_q   <= byp_w;
                  acc_x_q    <= '0;
                  acc_y_q    <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= MULT;
               end
            end
            MULT: begin
               if (bypass_q) begin
                  // Unscaled sample goes straight to the output registers.
                  x_out_q     <= op_x_q[POINT_WIDTH-1:0];
                  y_out_q     <= op_y_q[POINT_WIDTH-1:0];
                  z_out_q     <= z_q;
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end else begin
                  acc_x_q <= acc_x_d;
                  acc_y_q <= acc_y_d;
                  cnt_q   <= cnt_q + CW'(1);
                  if (cnt_q == LAST) begin
                     // Final bit: publish rounded x/y and z on the same edge.
                     x_out_q     <= round_q(acc_x_d);
                     y_out_q     <= round_q(acc_y_d);
                     z_out_q     <= z_q;
                     out_valid_q <= 1'b1;
                     state_q     <= HOLD;
                  end
               end
            end
            HOLD: begin
               // Outputs stay frozen until the consumer takes them; the next
               // sample is only accepted from the following cycle.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign x_out     = x_out_q;
   assign y_out     = y_out_q;
   assign z_out     = z_out_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Self-checking bench for cordic_gain_comp: vector table, backpressure,
// back-to-back, mid-multiply reset and randomized samples against a
// real-arithmetic reference of round(v * K_INV / 2^FRAC_BITS).
module tb_cordic_gain_comp;

   localparam int PW = 16;
   localparam int AWD = 16;
   localparam int FB = 15;
   localparam int KI = 19898;

   logic           clk;
   logic           rst;
   logic           bypass;
   logic           in_valid;
   logic           in_ready;
   logic [PW-1:0]  x_in;
   logic [PW-1:0]  y_in;
   logic [AWD-1:0] z_in;
   logic           out_valid;
   logic           out_ready;
   logic [PW-1:0]  x_out;
   logic [PW-1:0]  y_out;
   logic [AWD-1:0] z_out;

   int n_chk;
   int n_fail;

   cordic_gain_comp #(
      .POINT_WIDTH(PW),
      .ANGLE_WIDTH(AWD),
      .FRAC_BITS  (FB),
      .K_INV      (KI)
   ) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef CORDIC_GAIN_COMP_BYPASS_EN
      .bypass   (bypass),
`endif
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x_in     (x_in),
      .y_in     (y_in),
      .z_in     (z_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .x_out    (x_out),
      .y_out    (y_out),
      .z_out    (z_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          x;
      int          y;
      logic [15:0] z;
      int          ex;
      int          ey;
   } vec_t;

   vec_t tbl[7];
   int   smp[4];
   int   sexp[4];

   // Reference: exact product, scaled, rounded half up.
   function automatic int model(input int v);
      real r;
      r = (real'(v) * real'(KI)) / (2.0 ** FB);
      return int'($floor(r + 0.5));
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got timeout, required event", name);
   endtask

   function automatic int sx(input logic [PW-1:0] v);
      return int'($signed(v));
   endfunction

   // Called at a negedge. Presents a sample, waits for acceptance, then for
   // out_valid. lat counts rising edges after the accepting one.
   task automatic send(input int x, input int y, input logic [15:0] z, input logic byp,
                       output int rx, output int ry, output int rz, output int lat);
      int n;
      x_in = PW'(x); y_in = PW'(y); z_in = z; bypass = byp; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) tmo("accept_wait");
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
      if (lat >= 200) tmo("out_valid_wait");
      rx = sx(x_out); ry = sx(y_out); rz = int'(z_out);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b1;          // must be ignored during reset
      x_in = 16'd555; y_in = 16'd777; z_in = 16'h5555;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
   endtask

   int rx, ry, rz, lat;
   int k, got, c;
   bit adv, stale;
   int gx[4], gy[4], gz[4], gc[4];
   int rxv, ryv;

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1; bypass = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      x_in = '0; y_in = '0; z_in = '0;

      tbl[0] = '{x: 10000,  y: -10000, z: 16'h1234, ex: 6072,  ey: -6072};
      tbl[1] = '{x: 32767,  y: -32768, z: 16'hFFFF, ex: 19897, ey: -19898};
      tbl[2] = '{x: 1,      y: 0,      z: 16'h0001, ex: 1,     ey: 0};
      tbl[3] = '{x: 0,      y: 0,      z: 16'h0000, ex: 0,     ey: 0};
      tbl[4] = '{x: 100,    y: -100,   z: 16'hA5A5, ex: 61,    ey: -61};
      tbl[5] = '{x: 16384,  y: -16384, z: 16'h8000, ex: 9949,  ey: -9949};
      tbl[6] = '{x: -32768, y: 32767,  z: 16'h7FFF, ex: -19898, ey: 19897};
      smp  = '{0, 100, -100, 16384};
      sexp = '{0, 61, -61, 9949};

      @(negedge clk);
      do_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_x_out", x_out, 0);
      chk("rst_y_out", y_out, 0);
      chk("rst_z_out", z_out, 0);

      // Vector table, consumer always ready.
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send(tbl[i].x, tbl[i].y, tbl[i].z, 1'b0, rx, ry, rz, lat);
         chk($sformatf("tbl%0d_latency", i), lat, 16);
         chk($sformatf("tbl%0d_x", i), rx, tbl[i].ex);
         chk($sformatf("tbl%0d_y", i), ry, tbl[i].ey);
         chk($sformatf("tbl%0d_z", i), rz, int'(tbl[i].z));
         @(negedge clk);
         chk($sformatf("tbl%0d_out_valid_drop", i), out_valid, 0);
         chk($sformatf("tbl%0d_in_ready_back", i), in_ready, 1);
      end

      // Backpressure: consumer stalls, a second request waits.
      out_ready = 1'b0;
      send(10000, -10000, 16'h1234, 1'b0, rx, ry, rz, lat);
      chk("bp_latency", lat, 16);
      chk("bp_x", rx, 6072);
      x_in = PW'(-20000); y_in = PW'(300); z_in = 16'hBEEF; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_in_ready", in_ready, 0);
         chk("bp_hold_x", sx(x_out), 6072);
         chk("bp_hold_y", sx(y_out), -6072);
         chk("bp_hold_z", z_out, 16'h1234);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_in_ready", in_ready, 1);
      send(-20000, 300, 16'hBEEF, 1'b0, rx, ry, rz, lat);
      chk("bp_second_latency", lat, 16);
      chk("bp_second_x", rx, model(-20000));
      chk("bp_second_y", ry, model(300));
      chk("bp_second_z", rz, 16'hBEEF);
      @(negedge clk);

      // Back-to-back with in_valid held high.
      out_ready = 1'b1;
      k = 0; got = 0; adv = 0;
      x_in = PW'(smp[0]); y_in = PW'(-smp[0]); z_in = 16'(k); in_valid = 1'b1;
      for (c = 0; c < 300 && got < 4; c++) begin
         if (adv) begin
            adv = 0; k++;
            if (k < 4) begin x_in = PW'(smp[k]); y_in = PW'(-smp[k]); z_in = 16'(k); end
            else in_valid = 1'b0;
         end
         if (in_valid && in_ready) adv = 1;
         if (out_valid) begin
            gx[got] = sx(x_out); gy[got] = sx(y_out); gz[got] = int'(z_out); gc[got] = c;
            got++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (got < 4) tmo("b2b_outputs");
      for (int i = 0; i < got; i++) begin
         chk($sformatf("b2b%0d_x", i), gx[i], sexp[i]);
         chk($sformatf("b2b%0d_y", i), gy[i], -sexp[i]);
         chk($sformatf("b2b%0d_z", i), gz[i], i);
         if (i > 0) chk($sformatf("b2b%0d_spacing", i), gc[i] - gc[i-1], 18);
      end
      repeat (2) @(negedge clk);

      // Reset in the middle of the multiply loop.
      x_in = PW'(10000); y_in = PW'(-10000); z_in = 16'h1234; in_valid = 1'b1;
      while (!in_ready) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_x_out", x_out, 0);
      chk("midrst_y_out", y_out, 0);
      chk("midrst_z_out", z_out, 0);
      stale = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) stale = 1;
      end
      chk("midrst_no_stale", stale, 0);

      // Randomized samples with random consumer stalls.
      for (int i = 0; i < 24; i++) begin
         rxv = int'($urandom_range(0, 65535)) - 32768;
         ryv = int'($urandom_range(0, 65535)) - 32768;
         out_ready = 1'b0;
         send(rxv, ryv, 16'($urandom), 1'b0, rx, ry, rz, lat);
         chk($sformatf("rnd%0d_x(in %0d)", i, rxv), rx, model(rxv));
         chk($sformatf("rnd%0d_y(in %0d)", i, ryv), ry, model(ryv));
         chk($sformatf("rnd%0d_z", i), rz, int'(z_in));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk($sformatf("rnd%0d_hold_x", i), sx(x_out), model(rxv));
         out_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("rnd%0d_drop", i), out_valid, 0);
      end

`ifdef CORDIC_GAIN_COMP_BYPASS_EN
      out_ready = 1'b1;
      send(1234, -5, 16'd7, 1'b1, rx, ry, rz, lat);
      chk("byp_latency", lat, 1);
      chk("byp_x", rx, 1234);
      chk("byp_y", ry, -5);
      chk("byp_z", rz, 7);
      @(negedge clk);
      send(10000, -10000, 16'h1234, 1'b0, rx, ry, rz, lat);
      chk("nobyp_latency", lat, 16);
      chk("nobyp_x", rx, 6072);
      chk("nobyp_y", ry, -6072);
      chk("nobyp_z", rz, 16'h1234);
      @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
